// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the scene sequencer: FSM states, fade modes,
// the scene parameter record and its reset value.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_LOAD     = 2'd2,
        ST_FADE_IN  = 2'd3
    } scene_state_e;

    typedef enum logic [1:0] {
        FM_IDLE = 2'd0,
        FM_DOWN = 2'd1,
        FM_UP   = 2'd2
    } fade_mode_e;

    localparam logic [3:0]  BRIGHT_MAX  = 4'd15;
    localparam logic [11:0] FG_RESET    = 12'hFFF;
    localparam logic [11:0] BG_RESET    = 12'h000;
    localparam int          SLOPE_RESET = 1;

    typedef struct packed {
        logic [2:0]  pattern_sel;
        logic [4:0]  slope_a;
        logic [5:0]  offset_a;
        logic [2:0]  slope_b;
        logic [5:0]  offset_b;
        logic [11:0] fg_color;
        logic [11:0] bg_color;
    } scene_params_t;

    localparam scene_params_t PARAMS_RESET = '{
        pattern_sel: 3'd0,
        slope_a:     5'(SLOPE_RESET),
        offset_a:    6'd0,
        slope_b:     3'(SLOPE_RESET),
        offset_b:    6'd0,
        fg_color:    FG_RESET,
        bg_color:    BG_RESET
    };

    // A background identical to the foreground would hide the pattern, so invert instead.
    function automatic logic [11:0] pick_bg(input logic [11:0] fg, input logic [11:0] bg);
        return (bg == fg) ? ~fg : bg;
    endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Bundle of tempo/LFSR/frame inputs and scene parameter outputs of the sequencer.
interface scene_sequencer_if;
    logic        beat_pulse;
    logic        frame_start;
    logic        freeze;
    logic        skip;
    logic [12:0] rnd_0;
    logic [12:0] rnd_1;
    logic [12:0] rnd_2;
    logic [12:0] rnd_3;

    logic [2:0]  pattern_sel;
    logic [4:0]  slope_a;
    logic [5:0]  offset_a;
    logic [2:0]  slope_b;
    logic [5:0]  offset_b;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [3:0]  brightness;
    logic        scene_busy;
    logic [7:0]  scene_id;
    logic        scene_done;

    modport master (
        output beat_pulse, frame_start, freeze, skip, rnd_0, rnd_1, rnd_2, rnd_3,
        input  pattern_sel, slope_a, offset_a, slope_b, offset_b, fg_color, bg_color,
        input  brightness, scene_busy, scene_id, scene_done
    );

    modport slave (
        input  beat_pulse, frame_start, freeze, skip, rnd_0, rnd_1, rnd_2, rnd_3,
        output pattern_sel, slope_a, offset_a, slope_b, offset_b, fg_color, bg_color,
        output brightness, scene_busy, scene_id, scene_done
    );
endinterface

// File: rtl/fade_stepper.sv
// Frame divider plus brightness up/down counter. at_zero/at_max fire on the
// frame_start cycle whose step lands on 0 / BRIGHT_MAX.
module fade_stepper
    import vga_pattern_pkg::*;
#(
    parameter int FADE_STEP_FRAMES = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start_down,
    input  logic       start_up,
    input  logic       frame_start,
    output logic [3:0] brightness,
    output logic       at_zero,
    output logic       at_max
);

    localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

    fade_mode_e       mode_q, mode_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       bright_q, bright_d;

    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        bright_d    = bright_q;
        at_zero     = 1'b0;
        at_max      = 1'b0;
        if (start_down) begin
            mode_d      = FM_DOWN;
            frame_cnt_d = '0;
        end else if (start_up) begin
            mode_d      = FM_UP;
            frame_cnt_d = '0;
        end else if (frame_start && mode_q != FM_IDLE) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                if (mode_q == FM_DOWN) begin
                    bright_d = bright_q - 4'd1;
                    if (bright_q == 4'd1) begin
                        at_zero = 1'b1;
                        mode_d  = FM_IDLE;
                    end
                end else begin
                    bright_d = bright_q + 4'd1;
                    if (bright_q == BRIGHT_MAX - 4'd1) begin
                        at_max = 1'b1;
                        mode_d = FM_IDLE;
                    end
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            mode_q      <= FM_IDLE;
            frame_cnt_q <= '0;
            bright_q    <= BRIGHT_MAX;
        end else begin
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            bright_q    <= bright_d;
        end
    end

    assign brightness = bright_q;

endmodule

// File: rtl/scene_sequencer.sv
// Scene controller: counts beats, then fades out, loads new LFSR-derived
// parameters while black, and fades back in, all on frame boundaries.
//
// state       | meaning
// ST_RUN      | scene shown, beats counted, pending change waits for frame_start
// ST_FADE_OUT | brightness stepping down toward 0
// ST_LOAD     | one black cycle, new parameter set latched
// ST_FADE_IN  | brightness stepping up toward 15
module scene_sequencer
    import vga_pattern_pkg::*;
#(
    parameter int BEATS_PER_SCENE  = 8,
    parameter int FADE_STEP_FRAMES = 2,
    parameter int NUM_PATTERNS     = 6
) (
    input  logic              clk_in,
    input  logic              reset,
    scene_sequencer_if.slave  bus
);

    localparam int BEAT_W = (BEATS_PER_SCENE > 1) ? $clog2(BEATS_PER_SCENE) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_SCENE - 1);
    localparam logic [2:0] NUM_PAT = 3'(NUM_PATTERNS);

    scene_state_e      state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              pending_q, pending_d;
    logic              scene_busy_q, scene_busy_d;
    logic [7:0]        scene_id_q, scene_id_d;
    logic              scene_done_q, scene_done_d;
    scene_params_t     params_q, params_d;

    logic       start_down, start_up;
    logic       at_zero, at_max;
    logic       pend_set;
    logic [2:0] pat_raw;
    logic [3:0] brightness;
    logic       unused_rnd_bits;

    assign unused_rnd_bits = ^{bus.rnd_0[12], bus.rnd_1[12:11], bus.rnd_2[12], bus.rnd_3[12]};
    assign pat_raw = bus.rnd_0[2:0];

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        pending_d    = pending_q;
        scene_busy_d = scene_busy_q;
        scene_id_d   = scene_id_q;
        scene_done_d = 1'b0;
        params_d     = params_q;
        start_down   = 1'b0;
        start_up     = 1'b0;
        pend_set     = 1'b0;
        case (state_q)
            ST_RUN: begin
                pend_set = bus.skip;
                if (bus.beat_pulse && !bus.freeze) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d = '0;
                        pend_set   = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                // Only an already-registered request starts a fade on this frame.
                if (bus.frame_start && pending_q) begin
                    state_d      = ST_FADE_OUT;
                    scene_busy_d = 1'b1;
                    pending_d    = 1'b0;
                    beat_cnt_d   = '0;
                    start_down   = 1'b1;
                end else if (pend_set) begin
                    pending_d = 1'b1;
                end
            end
            ST_FADE_OUT: begin
                beat_cnt_d = '0;
                if (at_zero) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                beat_cnt_d           = '0;
                params_d.pattern_sel = (pat_raw >= NUM_PAT) ? pat_raw - NUM_PAT : pat_raw;
                params_d.slope_a     = (bus.rnd_1[4:0] == 5'd0) ? 5'd1 : bus.rnd_1[4:0];
                params_d.offset_a    = bus.rnd_1[10:5];
                params_d.slope_b     = (bus.rnd_0[5:3] == 3'd0) ? 3'd1 : bus.rnd_0[5:3];
                params_d.offset_b    = bus.rnd_0[11:6];
                params_d.fg_color    = bus.rnd_2[11:0];
                params_d.bg_color    = pick_bg(bus.rnd_2[11:0], bus.rnd_3[11:0]);
                scene_id_d           = scene_id_q + 8'd1;
                start_up             = 1'b1;
                state_d              = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                beat_cnt_d = '0;
                if (at_max) begin
                    state_d      = ST_RUN;
                    scene_busy_d = 1'b0;
                    scene_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            beat_cnt_q   <= '0;
            pending_q    <= 1'b0;
            scene_busy_q <= 1'b0;
            scene_id_q   <= 8'd0;
            scene_done_q <= 1'b0;
            params_q     <= PARAMS_RESET;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            pending_q    <= pending_d;
            scene_busy_q <= scene_busy_d;
            scene_id_q   <= scene_id_d;
            scene_done_q <= scene_done_d;
            params_q     <= params_d;
        end
    end

    fade_stepper #(
        .FADE_STEP_FRAMES (FADE_STEP_FRAMES)
    ) u_fade_stepper (
        .clk_in      (clk_in),
        .reset       (reset),
        .start_down  (start_down),
        .start_up    (start_up),
        .frame_start (bus.frame_start),
        .brightness  (brightness),
        .at_zero     (at_zero),
        .at_max      (at_max)
    );

    assign bus.pattern_sel = params_q.pattern_sel;
    assign bus.slope_a     = params_q.slope_a;
    assign bus.offset_a    = params_q.offset_a;
    assign bus.slope_b     = params_q.slope_b;
    assign bus.offset_b    = params_q.offset_b;
    assign bus.fg_color    = params_q.fg_color;
    assign bus.bg_color    = params_q.bg_color;
    assign bus.brightness  = brightness;
    assign bus.scene_busy  = scene_busy_q;
    assign bus.scene_id    = scene_id_q;
    assign bus.scene_done  = scene_done_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer: frame_start every 100 cycles, beats,
// skips and freeze driven from the main thread, expected values hand-derived.
module tb_scene_sequencer;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   frame_div = 0;

    always #5 clk_in = ~clk_in;

    scene_sequencer_if bus();

    scene_sequencer dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    // frame_start: one cycle high out of every 100, driven 1 time unit after the edge
    always @(posedge clk_in) begin
        #1;
        bus.frame_start = (frame_div == 99);
        frame_div = (frame_div == 99) ? 0 : frame_div + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    // Returns positioned inside the next frame_start cycle (before its edge).
    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!bus.frame_start && k < 300);
        if (!bus.frame_start) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_beat();
        bus.beat_pulse = 1'b1;
        step();
        bus.beat_pulse = 1'b0;
        step();
    endtask

    task automatic pulse_skip();
        bus.skip = 1'b1;
        step();
        bus.skip = 1'b0;
        step();
    endtask

    initial begin
        bus.beat_pulse  = 1'b0;
        bus.frame_start = 1'b0;
        bus.freeze      = 1'b0;
        bus.skip        = 1'b0;
        bus.rnd_0 = 13'h0007;
        bus.rnd_1 = 13'h0040;
        bus.rnd_2 = 13'h0F00;
        bus.rnd_3 = 13'h00F0;

        // 1: reset values
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_brightness", 32'(bus.brightness), 32'd15);
        chk("rst_fg", 32'(bus.fg_color), 32'hFFF);
        chk("rst_bg", 32'(bus.bg_color), 32'h000);
        chk("rst_slope_a", 32'(bus.slope_a), 32'd1);
        chk("rst_slope_b", 32'(bus.slope_b), 32'd1);
        chk("rst_pattern", 32'(bus.pattern_sel), 32'd0);
        chk("rst_scene_id", 32'(bus.scene_id), 32'd0);
        chk("rst_busy", 32'(bus.scene_busy), 32'd0);
        chk("rst_done", 32'(bus.scene_done), 32'd0);

        // 2: eight beats trigger a scene change
        wait_frame();
        step();
        repeat (8) pulse_beat();
        wait_frame();
        chk("t2_busy_before", 32'(bus.scene_busy), 32'd0);
        step();
        chk("t2_busy_rise", 32'(bus.scene_busy), 32'd1);
        chk("t2_bright_entry", 32'(bus.brightness), 32'd15);
        for (int i = 1; i <= 30; i++) begin
            wait_frame();
            step();
            if (i == 1)  chk("t2_fo_f1", 32'(bus.brightness), 32'd15);
            if (i == 2)  chk("t2_fo_f2", 32'(bus.brightness), 32'd14);
            if (i == 29) chk("t2_fo_f29", 32'(bus.brightness), 32'd1);
        end
        chk("t2_fo_zero", 32'(bus.brightness), 32'd0);
        chk("t2_fg_hold", 32'(bus.fg_color), 32'hFFF);
        chk("t2_id_hold", 32'(bus.scene_id), 32'd0);
        step();
        chk("t2_pattern", 32'(bus.pattern_sel), 32'd1);
        chk("t2_slope_a", 32'(bus.slope_a), 32'd1);
        chk("t2_offset_a", 32'(bus.offset_a), 32'd2);
        chk("t2_slope_b", 32'(bus.slope_b), 32'd1);
        chk("t2_offset_b", 32'(bus.offset_b), 32'd0);
        chk("t2_fg", 32'(bus.fg_color), 32'hF00);
        chk("t2_bg", 32'(bus.bg_color), 32'h0F0);
        chk("t2_scene_id", 32'(bus.scene_id), 32'd1);
        chk("t2_load_black", 32'(bus.brightness), 32'd0);
        for (int i = 1; i <= 30; i++) begin
            wait_frame();
            step();
            if (i == 2)  chk("t2_fi_f2", 32'(bus.brightness), 32'd1);
            if (i == 29) chk("t2_fi_f29", 32'(bus.brightness), 32'd14);
            if (i == 29) chk("t2_fi_done_early", 32'(bus.scene_done), 32'd0);
        end
        chk("t2_fi_max", 32'(bus.brightness), 32'd15);
        chk("t2_done_pulse", 32'(bus.scene_done), 32'd1);
        chk("t2_busy_fall", 32'(bus.scene_busy), 32'd0);
        step();
        chk("t2_done_one_cycle", 32'(bus.scene_done), 32'd0);

        // 4: freeze suppresses beats; skip still starts a sequence
        bus.rnd_0 = 13'h0ABC;
        bus.rnd_1 = 13'h1FFF;
        bus.rnd_2 = 13'h0123;
        bus.rnd_3 = 13'h0123;
        bus.freeze = 1'b1;
        repeat (20) pulse_beat();
        wait_frame();
        step();
        chk("t4_frozen_busy1", 32'(bus.scene_busy), 32'd0);
        wait_frame();
        step();
        chk("t4_frozen_busy2", 32'(bus.scene_busy), 32'd0);
        chk("t4_frozen_id", 32'(bus.scene_id), 32'd1);
        pulse_skip();
        wait_frame();
        chk("t4_skip_wait", 32'(bus.scene_busy), 32'd0);
        step();
        chk("t4_skip_start", 32'(bus.scene_busy), 32'd1);
        bus.freeze = 1'b0;

        // 3: equal fg/bg words invert the background; 5: inputs ignored in FADE_IN
        for (int i = 1; i <= 30; i++) begin
            wait_frame();
            step();
        end
        chk("t3_fo_zero", 32'(bus.brightness), 32'd0);
        step();
        chk("t3_fg", 32'(bus.fg_color), 32'h123);
        chk("t3_bg_inverted", 32'(bus.bg_color), 32'hEDC);
        chk("t3_pattern", 32'(bus.pattern_sel), 32'd4);
        chk("t3_slope_a", 32'(bus.slope_a), 32'd31);
        chk("t3_offset_a", 32'(bus.offset_a), 32'd63);
        chk("t3_slope_b", 32'(bus.slope_b), 32'd7);
        chk("t3_offset_b", 32'(bus.offset_b), 32'd42);
        chk("t3_scene_id", 32'(bus.scene_id), 32'd2);
        for (int i = 1; i <= 30; i++) begin
            wait_frame();
            step();
            if (i == 3) begin
                pulse_skip();
                repeat (5) pulse_beat();
                chk("t5_busy_hold", 32'(bus.scene_busy), 32'd1);
                chk("t5_bright_hold", 32'(bus.brightness), 32'd1);
            end
        end
        chk("t5_done_pulse", 32'(bus.scene_done), 32'd1);
        step();
        repeat (7) pulse_beat();
        wait_frame();
        step();
        chk("t5_seven_beats", 32'(bus.scene_busy), 32'd0);
        chk("t5_seven_id", 32'(bus.scene_id), 32'd2);
        pulse_beat();
        wait_frame();
        step();
        chk("t5_eighth_beat", 32'(bus.scene_busy), 32'd1);

        // 6: reset in the middle of FADE_OUT
        for (int i = 1; i <= 16; i++) begin
            wait_frame();
            step();
        end
        chk("t6_bright7", 32'(bus.brightness), 32'd7);
        reset = 1'b0;
        step();
        chk("t6_bright", 32'(bus.brightness), 32'd15);
        chk("t6_busy", 32'(bus.scene_busy), 32'd0);
        chk("t6_scene_id", 32'(bus.scene_id), 32'd0);
        chk("t6_fg", 32'(bus.fg_color), 32'hFFF);
        chk("t6_pattern", 32'(bus.pattern_sel), 32'd0);
        reset = 1'b1;
        step();
        wait_frame();
        step();
        chk("t6_run_idle", 32'(bus.scene_busy), 32'd0);
        chk("t6_run_bright", 32'(bus.brightness), 32'd15);
        pulse_skip();
        wait_frame();
        step();
        chk("t6_run_skip", 32'(bus.scene_busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Controller for the VGA pattern datapath. Counts tempo beats and decides when the on-screen pattern changes.
- On a change it fades brightness down frame by frame, then latches a new parameter set from the LFSR words while the screen is black, then fades back up.
- Parameter updates only happen at frame boundaries, so there is no tearing. It sits between the tempo, LFSR and vga_sync blocks and the pixel colour logic.

Parameters:
- BEATS_PER_SCENE, 8: beats per scene before an automatic change.
- FADE_STEP_FRAMES, 2: frame_start strobes per brightness step.
- NUM_PATTERNS, 6: number of selectable patterns (at most 8).

Ports:
- clk_in  in  1  pixel clock.
- reset  in  1  synchronous, active-low reset.
- beat_pulse  in  1  one-cycle tempo strobe.
- frame_start  in  1  one-cycle strobe on the first cycle of vertical blank.
- freeze  in  1  level; holds the current scene by suppressing beat counting.
- skip  in  1  one-cycle request for an immediate scene change.
- rnd_0..rnd_3  in  13 each  LFSR words.
- pattern_sel  out  3  pattern index.
- slope_a  out  5 ; offset_a  out  6 ; slope_b  out  3 ; offset_b  out  6  line-geometry terms.
- fg_color  out  12 ; bg_color  out  12  {r,g,b}, 4 bits each.
- brightness  out  4  0..15, applied by the colour stage.
- scene_busy  out  1  high during the fade/load sequence.
- scene_id  out  8  scene counter.
- scene_done  out  1  one-cycle pulse when a change completes.

Behaviour:
- Reset (reset==0 at a clk_in edge) sets, on the next cycle:
  - pattern_sel=0, slope_a=1, offset_a=0, slope_b=1, offset_b=0;
  - fg_color=12'hFFF, bg_color=12'h000, brightness=15;
  - scene_busy=0, scene_id=0, scene_done=0;
  - state RUN, beat_cnt=0, frame_cnt=0, pending=0.
- Reset asserted mid-sequence behaves the same: all state returns to reset values.
- States: RUN, FADE_OUT, LOAD, FADE_IN.
- RUN:
  - beat_pulse with freeze==0 increments beat_cnt.
  - A beat at beat_cnt==BEATS_PER_SCENE-1 instead clears beat_cnt and sets pending.
  - skip sets pending regardless of freeze. A simultaneous beat wrap and skip sets pending once.
  - frame_start with registered pending==1: next state FADE_OUT, scene_busy=1, pending cleared, frame_cnt=0.
  - A pending bit set in the same cycle as a frame_start waits for the following frame_start.
- FADE_OUT:
  - Each frame_start increments frame_cnt. At frame_cnt==FADE_STEP_FRAMES-1 it clears frame_cnt and decrements brightness.
  - The decrement from 1 to 0 moves the state to LOAD.
  - Fade-out length is 15*FADE_STEP_FRAMES frame_starts; the entry strobe is not counted.
- LOAD (exactly one cycle, brightness==0):
  - pattern_sel = rnd_0[2:0], minus NUM_PATTERNS if rnd_0[2:0] >= NUM_PATTERNS.
  - slope_a = rnd_1[4:0], forced to 1 if 0; offset_a = rnd_1[10:5].
  - slope_b = rnd_0[5:3], forced to 1 if 0; offset_b = rnd_0[11:6].
  - fg_color = rnd_2[11:0]; bg_color = rnd_3[11:0], or ~rnd_2[11:0] if rnd_3[11:0] equals rnd_2[11:0].
  - scene_id increments and wraps 255->0. frame_cnt=0. Next state FADE_IN.
- FADE_IN:
  - Same frame divider as FADE_OUT; brightness increments per step.
  - The increment to 15 returns to RUN, sets scene_busy=0 and pulses scene_done for exactly one cycle.
- While scene_busy=1:
  - beat_pulse is ignored and beat_cnt is held at 0.
  - skip is dropped (not queued).
  - freeze has no effect; a started sequence always completes.
- Geometry and colour outputs change only in LOAD. brightness changes only on a frame_start cycle's next edge.

Decomposition:
- Package vga_pattern_pkg holds:
  - the state enum (RUN/FADE_OUT/LOAD/FADE_IN);
  - BRIGHT_MAX=15;
  - reset constants FG_RESET=12'hFFF, BG_RESET=12'h000, SLOPE_RESET=1.
- One sub-module, fade_stepper. It contains the frame divider plus a brightness up/down counter, with inputs start_down, start_up and frame_start, and outputs brightness, at_zero (one-cycle) and at_max (one-cycle).
- The top holds the FSM, beat counter and parameter registers.

Test Plan:
All scenarios use defaults, with frame_start every 100 cycles.
1. Release reset -> next cycle brightness=15, fg_color=FFF, bg_color=000, slope_a=1, scene_id=0, scene_busy=0.
2. 8 beat_pulses; rnd_0=13'h0007, rnd_1=13'h0040, rnd_2=13'h0F00, rnd_3=13'h00F0 -> scene_busy rises the cycle after the next frame_start.
   - brightness 14 at the 2nd frame_start after entry, 0 at the 30th.
   - LOAD gives pattern_sel=1, slope_a=1 (forced), offset_a=2, slope_b=1 (forced), offset_b=0, fg=F00, bg=0F0, scene_id=1.
   - brightness reaches 15 after 30 more frame_starts; scene_done high exactly one cycle.
3. rnd_2=rnd_3=13'h0123 at LOAD -> bg_color=12'hEDC.
4. freeze=1 with 20 beats -> no scene_busy and scene_id unchanged. Then skip -> sequence starts at the next frame_start.
5. skip and 5 beats during FADE_IN -> ignored. After scene_done, 7 further beats give no change and the 8th sets pending.
6. reset low during FADE_OUT at brightness 7 -> next cycle brightness=15, scene_busy=0, scene_id=0, state RUN.
